// File: rtl/score_collector_if.sv
// Bundles the bank-side capture bus and the host-side result/max outputs of score_collector.
// slave is the collector's view; master is the bank/host environment's view.
interface score_collector_if #(
  parameter int SCORE_WIDTH = 12,
  parameter int ID_WIDTH    = 48,
  parameter int LANES       = 4,
  parameter int FIFO_DEPTH  = 16
);
  localparam int LANE_W = $clog2(LANES);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [0:LANES*SCORE_WIDTH-1] results;
  logic [0:LANES*ID_WIDTH-1]    IDs;
  logic [0:LANES-1]             vld;
  logic                         q_start;
  logic                         q_done;

  logic                         out_valid;
  logic                         out_ready;
  logic [SCORE_WIDTH-1:0]       out_score;
  logic [ID_WIDTH-1:0]          out_id;
  logic [LANE_W-1:0]            out_lane;
  logic [CNT_W-1:0]             fifo_count;

  logic [SCORE_WIDTH-1:0]       max_score;
  logic [ID_WIDTH-1:0]          max_id;
  logic                         max_vld;
  logic                         overflow;

  modport slave (
    input  results, IDs, vld, q_start, q_done, out_ready,
    output out_valid, out_score, out_id, out_lane, fifo_count,
    output max_score, max_id, max_vld, overflow
  );

  modport master (
    output results, IDs, vld, q_start, q_done, out_ready,
    input  out_valid, out_score, out_id, out_lane, fifo_count,
    input  max_score, max_id, max_vld, overflow
  );
endinterface

// File: rtl/score_collector.sv
// Drains per-lane bank results through a round-robin arbiter into a show-ahead FIFO,
// and tracks the best score/ID of the current query at capture time.
module score_collector #(
  parameter int          SCORE_WIDTH = 12,
  parameter int          ID_WIDTH    = 48,
  parameter int          LANES       = 4,
  parameter int          FIFO_DEPTH  = 16,
  parameter int unsigned ZERO        = 2**(SCORE_WIDTH-1)
) (
  input  logic             clk,
  input  logic             rst,
  score_collector_if.slave bus
);
  localparam int LANE_W = $clog2(LANES);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  typedef logic [SCORE_WIDTH-1:0] score_t;
  typedef logic [ID_WIDTH-1:0]    id_t;
  typedef logic [LANE_W-1:0]      lane_t;

  typedef struct packed {
    score_t score;
    id_t    id;
    lane_t  lane;
  } entry_t;

  localparam score_t ZERO_S = score_t'(ZERO);

  // Lane holding registers
  logic [LANES-1:0] pend_q, pend_d;
  score_t           hold_score_q [LANES];
  id_t              hold_id_q    [LANES];
  lane_t            rr_ptr_q, rr_ptr_d;

  // Output FIFO
  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  // Max tracking and report
  score_t           max_score_q, max_score_d;
  id_t              max_id_q, max_id_d;
  logic             max_vld_q;
  logic             rpt_hold_q;
  score_t           rpt_score_q;
  id_t              rpt_id_q;
  logic             overflow_q;

  score_t           lane_score [LANES];
  id_t              lane_id    [LANES];
  logic [LANES-1:0] grant_vec, accept, drop;
  logic             grant_any;
  lane_t            grant_idx;
  logic             pop, push, can_push;
  entry_t           wdata, head;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_score[k] = bus.results[k*SCORE_WIDTH +: SCORE_WIDTH];
      lane_id[k]    = bus.IDs[k*ID_WIDTH +: ID_WIDTH];
    end
  end

  assign pop      = (count_q != '0) && bus.out_ready;
  assign can_push = (count_q != CNT_W'(FIFO_DEPTH)) || pop;

  // First pending lane at or after rr_ptr wins.
  always_comb begin
    int cand;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = 0; i < LANES; i++) begin
      cand = (int'(rr_ptr_q) + i) % LANES;
      if (!grant_any && can_push && pend_q[lane_t'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = lane_t'(cand);
      end
    end
  end

  assign push  = grant_any;
  assign wdata = '{score: hold_score_q[grant_idx], id: hold_id_q[grant_idx], lane: grant_idx};

  // A lane granted this cycle frees its holding register for a same-cycle capture.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      grant_vec[k] = grant_any && (grant_idx == lane_t'(k));
      accept[k]    = bus.vld[k] && (!pend_q[k] || grant_vec[k]);
      drop[k]      = bus.vld[k] && !accept[k];
      pend_d[k]    = accept[k] | (pend_q[k] & ~grant_vec[k]);
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == lane_t'(LANES-1)) ? '0 : grant_idx + lane_t'(1);
    end
  end

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  // Strict comparisons keep the lowest lane on ties and the earlier result across cycles.
  always_comb begin
    logic   best_vld;
    score_t best_score;
    id_t    best_id;
    best_vld    = 1'b0;
    best_score  = '0;
    best_id     = '0;
    for (int k = 0; k < LANES; k++) begin
      if (bus.vld[k] && (!best_vld || (lane_score[k] > best_score))) begin
        best_vld   = 1'b1;
        best_score = lane_score[k];
        best_id    = lane_id[k];
      end
    end
    max_score_d = bus.q_start ? ZERO_S : max_score_q;
    max_id_d    = bus.q_start ? '0     : max_id_q;
    if (best_vld && (best_score > max_score_d)) begin
      max_score_d = best_score;
      max_id_d    = best_id;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      max_score_q <= ZERO_S;
      max_id_q    <= '0;
      max_vld_q   <= 1'b0;
      rpt_hold_q  <= 1'b0;
      rpt_score_q <= '0;
      rpt_id_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      max_score_q <= max_score_d;
      max_id_q    <= max_id_d;
      max_vld_q   <= bus.q_done;
      // A combined start/done reports the finished query, not the fold of the new one.
      rpt_hold_q  <= bus.q_start && bus.q_done;
      rpt_score_q <= max_score_q;
      rpt_id_q    <= max_id_q;
      if (|drop) overflow_q <= 1'b1;
    end
  end

  // NOTE: payload storage has no reset; it is only observed behind pend_q or a non-zero count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (accept[k]) begin
        hold_score_q[k] <= lane_score[k];
        hold_id_q[k]    <= lane_id[k];
      end
    end
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.out_valid  = (count_q != '0);
  assign bus.out_score  = bus.out_valid ? head.score : '0;
  assign bus.out_id     = bus.out_valid ? head.id    : '0;
  assign bus.out_lane   = bus.out_valid ? head.lane  : '0;
  assign bus.fifo_count = count_q;

  assign bus.max_score  = rpt_hold_q ? rpt_score_q : max_score_q;
  assign bus.max_id     = rpt_hold_q ? rpt_id_q    : max_id_q;
  assign bus.max_vld    = max_vld_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_score_collector.sv
// Directed bench for score_collector: a table of single-cycle vectors followed by
// hand-written sequences for FIFO saturation, combined start/done and async reset.
module tb_score_collector;
  localparam int SW = 12;
  localparam int IW = 48;
  localparam int NL = 4;
  localparam int FD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  score_collector_if #(.SCORE_WIDTH(SW), .ID_WIDTH(IW), .LANES(NL), .FIFO_DEPTH(FD)) bus ();

  score_collector #(.SCORE_WIDTH(SW), .ID_WIDTH(IW), .LANES(NL), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Per-lane packed arrays are written {lane3, lane2, lane1, lane0}.
  typedef struct {
    logic [3:0]       vld;
    logic [3:0][11:0] sc;
    logic [3:0][47:0] id;
    logic             qs;
    logic             qd;
    logic             e_valid;
    logic [11:0]      e_score;
    logic [47:0]      e_id;
    logic [1:0]       e_lane;
    logic [4:0]       e_cnt;
    logic [11:0]      e_max;
    logic [47:0]      e_maxid;
    logic             e_mvld;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0][11:0] sc,
                              input logic [3:0][47:0] id, input logic qs, input logic qd,
                              input logic ev, input logic [11:0] es, input logic [47:0] eid,
                              input logic [1:0] el, input logic [4:0] ec,
                              input logic [11:0] em, input logic [47:0] emid, input logic emv);
    vec_t v;
    v.vld = vld; v.sc = sc; v.id = id; v.qs = qs; v.qd = qd;
    v.e_valid = ev; v.e_score = es; v.e_id = eid; v.e_lane = el; v.e_cnt = ec;
    v.e_max = em; v.e_maxid = emid; v.e_mvld = emv;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [3:0] v, input logic [3:0][11:0] sc,
                       input logic [3:0][47:0] id, input logic qs, input logic qd,
                       input logic rdy);
    for (int k = 0; k < NL; k++) begin
      bus.vld[k]                = v[k];
      bus.results[k*SW +: SW]   = sc[k];
      bus.IDs[k*IW +: IW]       = id[k];
    end
    bus.q_start   = qs;
    bus.q_done    = qd;
    bus.out_ready = rdy;
  endtask

  task automatic pulse(input int lane, input logic [11:0] s, input logic [47:0] id,
                       input logic qs, input logic qd, input logic rdy);
    logic [3:0]       v;
    logic [3:0][11:0] sc;
    logic [3:0][47:0] ids;
    v = '0; sc = '0; ids = '0;
    v[lane] = 1'b1; sc[lane] = s; ids[lane] = id;
    apply(v, sc, ids, qs, qd, rdy);
  endtask

  task automatic idle(input logic qd, input logic rdy);
    apply('0, '0, '0, 1'b0, qd, rdy);
  endtask

  task automatic check_head(input string name, input logic [11:0] s, input logic [47:0] id,
                            input logic [1:0] lane);
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_score"}, 64'(bus.out_score), 64'(s));
    check({name, "_id"},    64'(bus.out_id),    64'(id));
    check({name, "_lane"},  64'(bus.out_lane),  64'(lane));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1'b0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //              vld      scores {l3,l2,l1,l0}           ids {l3,l2,l1,l0}                qs qd  ev es      eid     el ec  max     maxid   mvld
    vecs[0]  = mk(4'b0100, {12'h0,12'h850,12'h0,12'h0},   {48'h0,48'hA5,48'h0,48'h0},      0, 0,  0, 12'h0,  48'h0,  0, 0, 12'h850, 48'hA5,  0);
    vecs[1]  = mk(4'b0000, '0, '0,                                                          0, 0,  1, 12'h850,48'hA5,  2, 1, 12'h850, 48'hA5,  0);
    vecs[2]  = mk(4'b1000, {12'h810,12'h0,12'h0,12'h0},   {48'h33,48'h0,48'h0,48'h0},      0, 0,  0, 12'h0,  48'h0,  0, 0, 12'h850, 48'hA5,  0);
    vecs[3]  = mk(4'b0000, '0, '0,                                                          0, 0,  1, 12'h810,48'h33,  3, 1, 12'h850, 48'hA5,  0);
    vecs[4]  = mk(4'b1111, {12'h804,12'h803,12'h802,12'h801}, {48'h103,48'h102,48'h101,48'h100}, 1, 0, 0, 12'h0, 48'h0, 0, 0, 12'h804, 48'h103, 0);
    vecs[5]  = mk(4'b0000, '0, '0,                                                          0, 0,  1, 12'h801,48'h100, 0, 1, 12'h804, 48'h103, 0);
    vecs[6]  = mk(4'b0000, '0, '0,                                                          0, 0,  1, 12'h802,48'h101, 1, 1, 12'h804, 48'h103, 0);
    vecs[7]  = mk(4'b0000, '0, '0,                                                          0, 1,  1, 12'h803,48'h102, 2, 1, 12'h804, 48'h103, 1);
    vecs[8]  = mk(4'b0000, '0, '0,                                                          0, 0,  1, 12'h804,48'h103, 3, 1, 12'h804, 48'h103, 0);
    vecs[9]  = mk(4'b0000, '0, '0,                                                          0, 0,  0, 12'h0,  48'h0,   0, 0, 12'h804, 48'h103, 0);
    vecs[10] = mk(4'b1010, {12'h900,12'h0,12'h900,12'h0}, {48'h203,48'h0,48'h201,48'h0},   1, 0,  0, 12'h0,  48'h0,   0, 0, 12'h900, 48'h201, 0);
    vecs[11] = mk(4'b0001, {12'h0,12'h0,12'h0,12'h900},  {48'h0,48'h0,48'h0,48'h200},      0, 0,  1, 12'h900,48'h201, 1, 1, 12'h900, 48'h201, 0);
    vecs[12] = mk(4'b0000, '0, '0,                                                          0, 0,  1, 12'h900,48'h203, 3, 1, 12'h900, 48'h201, 0);
    vecs[13] = mk(4'b0000, '0, '0,                                                          0, 0,  1, 12'h900,48'h200, 0, 1, 12'h900, 48'h201, 0);
    vecs[14] = mk(4'b0000, '0, '0,                                                          0, 1,  0, 12'h0,  48'h0,   0, 0, 12'h900, 48'h201, 1);

    // Reset values
    idle(1'b0, 1'b0);
    #23;
    check("rst_valid",    64'(bus.out_valid),  64'd0);
    check("rst_score",    64'(bus.out_score),  64'd0);
    check("rst_id",       64'(bus.out_id),     64'd0);
    check("rst_lane",     64'(bus.out_lane),   64'd0);
    check("rst_count",    64'(bus.fifo_count), 64'd0);
    check("rst_max",      64'(bus.max_score),  64'h800);
    check("rst_maxid",    64'(bus.max_id),     64'd0);
    check("rst_maxvld",   64'(bus.max_vld),    64'd0);
    check("rst_overflow", 64'(bus.overflow),   64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table: single result, lane-3 result, 4-lane burst with q_done, tie handling
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].vld, vecs[i].sc, vecs[i].id, vecs[i].qs, vecs[i].qd, 1'b1);
      step();
      check($sformatf("v%0d_valid", i), 64'(bus.out_valid),  64'(vecs[i].e_valid));
      check($sformatf("v%0d_count", i), 64'(bus.fifo_count), 64'(vecs[i].e_cnt));
      check($sformatf("v%0d_max", i),   64'(bus.max_score),  64'(vecs[i].e_max));
      check($sformatf("v%0d_maxid", i), 64'(bus.max_id),     64'(vecs[i].e_maxid));
      check($sformatf("v%0d_mvld", i),  64'(bus.max_vld),    64'(vecs[i].e_mvld));
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d_score", i), 64'(bus.out_score), 64'(vecs[i].e_score));
        check($sformatf("v%0d_id", i),    64'(bus.out_id),    64'(vecs[i].e_id));
        check($sformatf("v%0d_lane", i),  64'(bus.out_lane),  64'(vecs[i].e_lane));
      end
    end

    // Saturation: 20 results with out_ready low, one extra same-lane pulse is dropped
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pulse(i % 4, 12'(12'h801 + i), 48'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    pulse(2, 12'h900, 48'h99, 1'b0, 1'b0, 1'b0);
    step();
    check("sat_count",    64'(bus.fifo_count), 64'd16);
    check("sat_overflow", 64'(bus.overflow),   64'd1);
    check("sat_max",      64'(bus.max_score),  64'h900);
    check("sat_maxid",    64'(bus.max_id),     64'h99);
    check_head("sat_head", 12'h801, 48'd0, 2'd0);
    idle(1'b0, 1'b0);
    step();
    check_head("sat_hold", 12'h801, 48'd0, 2'd0);
    check("sat_hold_count", 64'(bus.fifo_count), 64'd16);
    idle(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check_head($sformatf("drain%0d", i), 12'(12'h801 + i), 48'(i), 2'(i % 4));
      step();
    end
    check("drain_valid",    64'(bus.out_valid),  64'd0);
    check("drain_count",    64'(bus.fifo_count), 64'd0);
    check("drain_overflow", 64'(bus.overflow),   64'd1);

    // q_start and q_done together, then back-to-back q_done
    do_reset();
    pulse(0, 12'h8A0, 48'hA0, 1'b0, 1'b0, 1'b1);
    step();
    check("sd_pre_max", 64'(bus.max_score), 64'h8A0);
    pulse(1, 12'h830, 48'h31, 1'b1, 1'b1, 1'b1);
    step();
    check("sd_rpt_mvld",  64'(bus.max_vld),   64'd1);
    check("sd_rpt_max",   64'(bus.max_score), 64'h8A0);
    check("sd_rpt_maxid", 64'(bus.max_id),    64'hA0);
    idle(1'b0, 1'b1);
    step();
    check("sd_after_mvld", 64'(bus.max_vld),   64'd0);
    check("sd_after_max",  64'(bus.max_score), 64'h830);
    idle(1'b1, 1'b1);
    step();
    check("sd_next_mvld",  64'(bus.max_vld),   64'd1);
    check("sd_next_max",   64'(bus.max_score), 64'h830);
    check("sd_next_maxid", 64'(bus.max_id),    64'h31);
    idle(1'b1, 1'b1);
    step();
    check("sd_b2b_mvld", 64'(bus.max_vld), 64'd1);
    idle(1'b0, 1'b1);
    step();
    check("sd_end_mvld", 64'(bus.max_vld), 64'd0);

    // Asynchronous reset with 5 queued entries
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse(i % 4, 12'(12'h8C0 + i), 48'(12'h50 + i), 1'b0, 1'b0, 1'b0);
      step();
    end
    idle(1'b0, 1'b0);
    step();
    check("ar_pre_count", 64'(bus.fifo_count), 64'd5);
    check("ar_pre_max",   64'(bus.max_score),  64'h8C4);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 64'(bus.out_valid),  64'd0);
    check("ar_count", 64'(bus.fifo_count), 64'd0);
    check("ar_max",   64'(bus.max_score),  64'h800);
    check("ar_score", 64'(bus.out_score),  64'd0);
    step();
    rst = 1'b0;
    idle(1'b0, 1'b1);
    step();
    step();
    check("ar_post_valid",    64'(bus.out_valid), 64'd0);
    check("ar_post_overflow", 64'(bus.overflow),  64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
